// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: start/serve/play/point/over flow, score keeping and winner detection.
// Define PONG_UART_CMD_EN to qualify start by START_BYTE and enable the RESET_BYTE abort command.
module pong_match_ctrl #(
  parameter int unsigned SCORE_LIMIT  = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter logic [7:0]  START_BYTE   = 8'h53,
  parameter logic [7:0]  RESET_BYTE   = 8'h52
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_Frame_Tick,
  input  logic       i_P1_Miss,
  input  logic       i_P2_Miss,
  output logic       o_Game_Active,
  output logic       o_Ball_Reset,
  output logic [3:0] o_Score_P1,
  output logic [3:0] o_Score_P2,
  output logic [1:0] o_Winner,
  output logic [2:0] o_State
);

  // state | meaning
  // IDLE  | waiting for first start command, ball held
  // SERVE | ball held, counting down frame ticks
  // PLAY  | ball live, watching for misses
  // POINT | one cycle after a score, decide win or re-serve
  // OVER  | winner declared, scores frozen until next start
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] LIMIT  = 4'(SCORE_LIMIT);
  localparam logic [7:0] FRAMES = 8'(SERVE_FRAMES);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score_p1_q, score_p1_d;
  logic [3:0] score_p2_q, score_p2_d;
  logic [1:0] winner_q, winner_d;
  logic       game_active_q, ball_reset_q;
  logic       start_cmd, abort_cmd;

`ifdef PONG_UART_CMD_EN
  assign start_cmd = i_RX_DV && (i_RX_Byte == START_BYTE);
  assign abort_cmd = i_RX_DV && (i_RX_Byte == RESET_BYTE);
`else
  logic unused_cfg;
  assign unused_cfg = ^{START_BYTE, RESET_BYTE, i_RX_Byte};
  assign start_cmd  = i_RX_DV;
  assign abort_cmd  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    winner_d   = winner_q;
    if (abort_cmd) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      score_p1_d = '0;
      score_p2_d = '0;
      winner_d   = 2'b00;
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_cmd) begin
            state_d    = ST_SERVE;
            cnt_d      = FRAMES;
            score_p1_d = '0;
            score_p2_d = '0;
            winner_d   = 2'b00;
          end
        end
        ST_SERVE: begin
          if (cnt_q == '0) state_d = ST_PLAY;
          else if (i_Frame_Tick) cnt_d = cnt_q - 8'd1;
        end
        ST_PLAY: begin
          // simultaneous misses are a dead ball: replay without scoring
          if (i_P1_Miss && i_P2_Miss) begin
            state_d = ST_SERVE;
            cnt_d   = FRAMES;
          end else if (i_P2_Miss) begin
            state_d    = ST_POINT;
            score_p1_d = score_p1_q + 4'd1;
          end else if (i_P1_Miss) begin
            state_d    = ST_POINT;
            score_p2_d = score_p2_q + 4'd1;
          end
        end
        ST_POINT: begin
          // only the player who just scored can have reached the limit
          if (score_p1_q == LIMIT) begin
            state_d  = ST_OVER;
            winner_d = 2'b01;
          end else if (score_p2_q == LIMIT) begin
            state_d  = ST_OVER;
            winner_d = 2'b10;
          end else begin
            state_d = ST_SERVE;
            cnt_d   = FRAMES;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      score_p1_q    <= '0;
      score_p2_q    <= '0;
      winner_q      <= 2'b00;
      game_active_q <= 1'b0;
      ball_reset_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_p1_q    <= score_p1_d;
      score_p2_q    <= score_p2_d;
      winner_q      <= winner_d;
      game_active_q <= (state_d == ST_PLAY);
      ball_reset_q  <= (state_d != ST_PLAY);
    end
  end

  assign o_Game_Active = game_active_q;
  assign o_Ball_Reset  = ball_reset_q;
  assign o_Score_P1    = score_p1_q;
  assign o_Score_P2    = score_p2_q;
  assign o_Winner      = winner_q;
  assign o_State       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match flow plus random stimulus against a behavioural match model.
module tb_pong_match_ctrl;
  localparam int SL = 3;
  localparam int SF = 3;
  localparam logic [7:0] START_B = 8'h53;
  localparam logic [7:0] RESET_B = 8'h52;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tick = 1'b0, p1m = 1'b0, p2m = 1'b0;
  logic       ga, br;
  logic [3:0] s1, s2;
  logic [1:0] win;
  logic [2:0] st;

  int n_checks = 0;
  int n_pass   = 0;

  // model of the match: phase 0 idle,1 serve,2 play,3 point,4 over
  int m_phase = 0, m_wait = 0, m_p1 = 0, m_p2 = 0, m_win = 0;

  pong_match_ctrl #(.SCORE_LIMIT(SL), .SERVE_FRAMES(SF), .START_BYTE(START_B), .RESET_BYTE(RESET_B)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .i_Frame_Tick(tick), .i_P1_Miss(p1m), .i_P2_Miss(p2m),
    .o_Game_Active(ga), .o_Ball_Reset(br), .o_Score_P1(s1), .o_Score_P2(s2),
    .o_Winner(win), .o_State(st)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    bit is_start, is_abort;
    if (!rst_n) begin
      m_phase = 0; m_wait = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
    end else begin
`ifdef PONG_UART_CMD_EN
      is_start = rx_dv && rx_byte == START_B;
      is_abort = rx_dv && rx_byte == RESET_B;
`else
      is_start = rx_dv;
      is_abort = 1'b0;
`endif
      if (is_abort) begin
        m_phase = 0; m_wait = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
      end else if ((m_phase == 0 || m_phase == 4) && is_start) begin
        m_phase = 1; m_wait = SF; m_p1 = 0; m_p2 = 0; m_win = 0;
      end else if (m_phase == 1) begin
        if (m_wait == 0) m_phase = 2;
        else if (tick) m_wait = m_wait - 1;
      end else if (m_phase == 2) begin
        if (p1m && p2m) begin m_phase = 1; m_wait = SF; end
        else if (p2m) begin m_p1 = m_p1 + 1; m_phase = 3; end
        else if (p1m) begin m_p2 = m_p2 + 1; m_phase = 3; end
      end else if (m_phase == 3) begin
        if (m_p1 == SL) begin m_win = 1; m_phase = 4; end
        else if (m_p2 == SL) begin m_win = 2; m_phase = 4; end
        else begin m_phase = 1; m_wait = SF; end
      end
    end
  end

  always @(negedge clk) begin
    logic [14:0] act, exp_v;
    if (rst_n) begin
      act   = {ga, br, s1, s2, win, st};
      exp_v = {(m_phase == 2), (m_phase != 2), 4'(m_p1), 4'(m_p2), 2'(m_win), 3'(m_phase)};
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL model_cmp t=%0t: got ga/br/p1/p2/win/st=%h expected %h", $time, act, exp_v);
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
  endtask

  task automatic step(input logic dv, input logic [7:0] b, input logic t, input logic m1, input logic m2);
    @(negedge clk);
    rx_dv = dv; rx_byte = b; tick = t; p1m = m1; p2m = m2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic serve_to_play(input string nm);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    chk({nm, "_still_serve"}, int'(st), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk({nm, "_serve_after_last_tick"}, int'(st), 1);
    idle();
    chk({nm, "_play"}, int'(st), 2);
    chk({nm, "_active"}, int'(ga), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(st), 0);
    chk("reset_ball", int'(br), 1);
    chk("reset_active", int'(ga), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("idle_ignores", int'(st), 0);

    step(1'b1, START_B, 1'b0, 1'b0, 1'b0);
    chk("start_serve", int'(st), 1);
    chk("start_ball_held", int'(br), 1);
    serve_to_play("first_serve");

    step(1'b1, START_B, 1'b0, 1'b0, 1'b0);
    chk("start_in_play_ignored", int'(st), 2);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("p2miss_p1_score", int'(s1), 1);
    chk("p2miss_p2_score", int'(s2), 0);
    chk("p2miss_point", int'(st), 3);
    chk("p2miss_inactive", int'(ga), 0);
    idle();
    chk("point_to_serve", int'(st), 1);
    serve_to_play("reload");

    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("double_miss_serve", int'(st), 1);
    chk("double_miss_p1", int'(s1), 1);
    chk("double_miss_p2", int'(s2), 0);
    serve_to_play("replay");

    for (int k = 1; k <= SL; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("p2_points", int'(s2), k);
      idle();
      if (k < SL) serve_to_play("rally");
    end
    chk("over_state", int'(st), 4);
    chk("over_winner", int'(win), 2);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    idle();
    chk("over_frozen_state", int'(st), 4);
    chk("over_frozen_p2", int'(s2), SL);
    step(1'b1, START_B, 1'b0, 1'b0, 1'b0);
    chk("restart_state", int'(st), 1);
    chk("restart_p2", int'(s2), 0);
    chk("restart_winner", int'(win), 0);

    serve_to_play("pre_reset");
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle();
    chk("pre_reset_serve", int'(st), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_state", int'(st), 0);
    chk("async_p1", int'(s1), 0);
    chk("async_ball", int'(br), 1);
    chk("async_active", int'(ga), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle();
    chk("after_reset_idle", int'(st), 0);

`ifdef PONG_UART_CMD_EN
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    chk("other_byte_idle", int'(st), 0);
    step(1'b1, START_B, 1'b0, 1'b0, 1'b0);
    serve_to_play("uart");
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle();
    serve_to_play("uart2");
    step(1'b1, RESET_B, 1'b1, 1'b1, 1'b0);
    chk("abort_idle", int'(st), 0);
    chk("abort_p1", int'(s1), 0);
    chk("abort_p2", int'(s2), 0);
`endif

    for (int i = 0; i < 4000; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 3))
        0: b = START_B;
        1: b = RESET_B;
        2: b = 8'h41;
        default: b = 8'($urandom);
      endcase
      step($urandom_range(0, 15) == 0, b, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
